// File: rtl/byte_queue_pkg.sv
// Shared widths, default sizing and types for the byte queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package byte_queue_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LEN_W  = 8;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // Occupancy counter must hold 0..depth inclusive, one bit wider than a pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_queue_if.sv
// Request/response bundle between the deserializer side and the byte queue.
// Latency: n/a (wires only).
// Backpressure: none; full pushes are dropped, empty pops are ignored.
// Optional status flags are present when BYTE_QUEUE_STATUS_EN is defined.
interface byte_queue_if #(
    parameter int DATA_W = byte_queue_pkg::DATA_W
);

    logic [DATA_W-1:0]                data_in;
    logic                             enq_in;
    logic                             deq_in;
    logic [DATA_W-1:0]                data_out;
    logic [byte_queue_pkg::LEN_W-1:0] len_out;

`ifdef BYTE_QUEUE_STATUS_EN
    logic                             full_out;
    logic                             empty_out;

    modport master (
        output data_in, enq_in, deq_in,
        input  data_out, len_out, full_out, empty_out
    );

    modport slave (
        input  data_in, enq_in, deq_in,
        output data_out, len_out, full_out, empty_out
    );
`else
    modport master (
        output data_in, enq_in, deq_in,
        input  data_out, len_out
    );

    modport slave (
        input  data_in, enq_in, deq_in,
        output data_out, len_out
    );
`endif

endinterface

// File: rtl/byte_queue_mem.sv
// Storage array for the byte queue: synchronous write, asynchronous read.
// Latency: write visible on the edge after wr_en; read is combinational.
// Backpressure: none; the caller decides when a write is legal.
module byte_queue_mem
    import byte_queue_pkg::*;
#(
    parameter int DATA_W = byte_queue_pkg::DATA_W,
    parameter int DEPTH  = byte_queue_pkg::DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are deliberately left unreset; only the control state is cleared.
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the byte on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/byte_queue.sv
// Byte FIFO between the serial-to-parallel converter and the output stage.
// Latency: pops update data_out/len_out on the sampling edge; pushes are poppable one edge later.
// Backpressure: none; push when full (without pop) is dropped, pop when empty is ignored.
// Optional full_out/empty_out flags are built when BYTE_QUEUE_STATUS_EN is defined.
module byte_queue #(
    parameter int DATA_W = byte_queue_pkg::DATA_W,
    parameter int DEPTH  = byte_queue_pkg::DEPTH
) (
    input  logic        clock_10,
    input  logic        reset,
    byte_queue_if.slave bus
);
    import byte_queue_pkg::*;

    localparam int                AW       = $clog2(DEPTH);
    localparam int                CNT_W    = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_data;
    logic              deq_ok;
    logic              enq_ok;

    // Accept decisions: a pop frees a slot in the same edge, so a full queue
    // still takes a push alongside a pop; an empty queue never pops.
    always_comb begin
        deq_ok = bus.deq_in && (count != '0);
        enq_ok = bus.enq_in && ((count != FULL_CNT) || deq_ok);
    end

    byte_queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clock_10),
        .wr_en   (enq_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Write pointer advances once per accepted push and wraps modulo DEPTH.
    always_ff @(posedge clock_10 or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (enq_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer and output register advance together on an accepted pop.
    always_ff @(posedge clock_10 or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            data_q <= '0;
        end else if (deq_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
            data_q <= rd_data;
        end
    end

    // Occupancy: net change is push minus pop, unchanged when both or neither.
    always_ff @(posedge clock_10 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.data_out = data_q;
    assign bus.len_out  = LEN_W'(count);

`ifdef BYTE_QUEUE_STATUS_EN
    // Flags follow count directly, so reset yields full=0, empty=1 for free.
    assign bus.full_out  = (count == FULL_CNT);
    assign bus.empty_out = (count == '0);
`else
`endif

endmodule

// File: tb/tb_byte_queue.sv
// Self-checking bench for byte_queue against a queue-based reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_byte_queue;
    import byte_queue_pkg::*;

    localparam int QD = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    byte_queue_if bus ();

    byte_queue dut (
        .clock_10 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    int    checks = 0;
    int    errors = 0;
    byte_t mq[$];
    byte_t m_out;

    // Drive one request set, clock it in, and advance the reference model.
    task automatic step(input logic e, input logic d, input byte_t din);
        bit dok;
        bit eok;
        bus.enq_in  = e;
        bus.deq_in  = d;
        bus.data_in = din;
        @(posedge clk);
        if (rst_n) begin
            dok = d && (mq.size() > 0);
            eok = e && ((mq.size() < QD) || dok);
            if (dok) m_out = mq.pop_front();
            if (eok) mq.push_back(din);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mq.delete();
        m_out = '0;
        for (int i = 0; i < 6; i++) begin
            bus.enq_in  = 1'($urandom);
            bus.deq_in  = 1'($urandom);
            bus.data_in = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (bus.len_out !== 8'd0) begin
                errors++;
                $display("FAIL reset_len cycle %0d: got %0d want 0", i, bus.len_out);
            end
            checks++;
            if (bus.data_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_data cycle %0d: got %02h want 00", i, bus.data_out);
            end
        end
`ifdef BYTE_QUEUE_STATUS_EN
        checks++;
        if (bus.full_out !== 1'b0 || bus.empty_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: full %b empty %b want 0 1", bus.full_out, bus.empty_out);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i * 17));
            checks++;
            if (bus.len_out !== 8'(i)) begin
                errors++;
                $display("FAIL fill_len push %0d: got %0d want %0d", i, bus.len_out, i);
            end
        end
        step(1'b1, 1'b0, 8'h99);
        checks++;
        if (bus.len_out !== 8'd8) begin
            errors++;
            $display("FAIL full_drop_len: got %0d want 8", bus.len_out);
        end
        for (int i = 1; i <= 9; i++) begin
            byte_t exp_d;
            int    exp_l;
            exp_d = (i <= 8) ? 8'(i * 17) : 8'h88;
            exp_l = (i <= 8) ? 8 - i : 0;
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.data_out !== exp_d) begin
                errors++;
                $display("FAIL drain_data pop %0d: got %02h want %02h", i, bus.data_out, exp_d);
            end
            checks++;
            if (bus.len_out !== 8'(exp_l)) begin
                errors++;
                $display("FAIL drain_len pop %0d: got %0d want %0d", i, bus.len_out, exp_l);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.data_out !== m_out) begin
                errors++;
                $display("FAIL wrap_pre pop %0d: got %02h want %02h", i, bus.data_out, m_out);
            end
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
        checks++;
        if (bus.len_out !== 8'd8) begin
            errors++;
            $display("FAIL wrap_len: got %0d want 8", bus.len_out);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.data_out !== 8'(8'hA0 + i)) begin
                errors++;
                $display("FAIL wrap_data pop %0d: got %02h want %02h", i, bus.data_out, 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_simultaneous();
        byte_t oldest;
        byte_t prev;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
        oldest = mq[0];
        step(1'b1, 1'b1, 8'hC3);
        checks++;
        if (bus.len_out !== 8'd8) begin
            errors++;
            $display("FAIL both_full_len: got %0d want 8", bus.len_out);
        end
        checks++;
        if (bus.data_out !== oldest) begin
            errors++;
            $display("FAIL both_full_data: got %02h want %02h", bus.data_out, oldest);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.data_out !== 8'hC3 || bus.len_out !== 8'd0) begin
            errors++;
            $display("FAIL both_full_tail: got %02h/%0d want c3/0", bus.data_out, bus.len_out);
        end
        prev = m_out;
        step(1'b1, 1'b1, 8'h3C);
        checks++;
        if (bus.len_out !== 8'd1) begin
            errors++;
            $display("FAIL both_empty_len: got %0d want 1", bus.len_out);
        end
        checks++;
        if (bus.data_out !== prev) begin
            errors++;
            $display("FAIL both_empty_data: got %02h want %02h", bus.data_out, prev);
        end
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.data_out !== 8'h3C) begin
            errors++;
            $display("FAIL both_empty_pop: got %02h want 3c", bus.data_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));
        checks++;
        if (bus.len_out !== 8'd4) begin
            errors++;
            $display("FAIL areset_pre_len: got %0d want 4", bus.len_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_out = '0;
        checks++;
        if (bus.len_out !== 8'd0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL areset_now: got len %0d data %02h want 0 00", bus.len_out, bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.len_out !== 8'd0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL areset_deq_ignored: got len %0d data %02h want 0 00", bus.len_out, bus.data_out);
        end
        step(1'b1, 1'b0, 8'h5A);
        checks++;
        if (bus.len_out !== 8'd1) begin
            errors++;
            $display("FAIL areset_first_push: got %0d want 1", bus.len_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int pe;
            pe = (i < 300) ? 70 : 35;
            step(($urandom_range(0, 99) < pe), ($urandom_range(0, 99) < 50), 8'($urandom));
            checks++;
            if (bus.len_out !== 8'(mq.size())) begin
                errors++;
                $display("FAIL rand_len cycle %0d: got %0d want %0d", i, bus.len_out, mq.size());
            end
            checks++;
            if (bus.data_out !== m_out) begin
                errors++;
                $display("FAIL rand_data cycle %0d: got %02h want %02h", i, bus.data_out, m_out);
            end
`ifdef BYTE_QUEUE_STATUS_EN
            checks++;
            if (bus.full_out !== (mq.size() == QD) || bus.empty_out !== (mq.size() == 0)) begin
                errors++;
                $display("FAIL rand_status cycle %0d: full %b empty %b size %0d",
                         i, bus.full_out, bus.empty_out, mq.size());
            end
`endif
        end
    endtask

    initial begin
        bus.enq_in  = 1'b0;
        bus.deq_in  = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
